// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sharing arbiter: one-hot FSM encoding and
// the default sample width.
package adc_pkg;

   localparam int ADC_DATA_W = 12;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_REQ  = 4'b0010,
      ST_WAIT = 4'b0100,
      ST_DONE = 4'b1000
   } state_t;

endpackage

// File: rtl/adc_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr+1, wrapping at N.
module rr_pick
   import adc_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] grant,
   output logic          valid
);

   logic [PW-1:0] idx;

   // Walk from farthest to nearest so the nearest set bit is written last.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = N; i >= 1; i--) begin
         idx = PW'((int'(ptr) + i) % N);
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adc_arbiter.sv
// Round-robin sharing of a single ADC among N_CH channels, each speaking the
// same level req/ready handshake, with a conversion timeout.
module adc_arbiter
   import adc_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int DATA_W  = ADC_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [N_CH-1:0]          ch_req_i,
   output logic [N_CH-1:0]          ch_rdy_o,
   output logic [N_CH*DATA_W-1:0]   ch_data_o,
   output logic                     adc_req_o,
   input  logic                     adc_rdy_i,
   input  logic [DATA_W-1:0]        adc_data_i,
   output logic                     busy_o,
   output logic                     timeout_o
);

   localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW = $clog2(TIMEOUT);

   state_t state, state_nxt;

   logic [N_CH-1:0]   pending;
   logic [N_CH-1:0]   rdy_r;
   logic [N_CH-1:0]   accept;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     grant;
   logic [PW-1:0]     pick;
   logic              pick_valid;
   logic [DATA_W-1:0] data_r [N_CH];

   logic              rdy_q;
   logic              rdy_d;
   logic [DATA_W-1:0] data_q;
   logic              rdy_rise;

   logic [CW-1:0]     cnt;
   logic              tmo_hit;
   logic              tmo_r;

   logic              take;
   logic              capture;
   logic              abort;
   logic              finish;

   // A channel is only accepted while idle; this also ignores the granted
   // channel's req until its completion has cleared pending.
   assign accept   = ch_req_i & rdy_r & ~pending;
   assign rdy_rise = rdy_q & ~rdy_d;
   assign tmo_hit  = (cnt == CW'(TIMEOUT - 1));

   rr_pick #(
      .N  (N_CH),
      .PW (PW)
   ) u_pick (
      .req   (pending),
      .ptr   (ptr),
      .grant (pick),
      .valid (pick_valid)
   );

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      capture   = 1'b0;
      abort     = 1'b0;
      finish    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               take      = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (tmo_hit) begin
               abort     = 1'b1;
               state_nxt = ST_DONE;
            end else if (!rdy_q) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (tmo_hit) begin
               abort     = 1'b1;
               state_nxt = ST_DONE;
            end else if (rdy_rise) begin
               capture   = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state   <= ST_IDLE;
         pending <= '0;
         rdy_r   <= '1;
         ptr     <= PW'(N_CH - 1);
         grant   <= '0;
         cnt     <= '0;
         tmo_r   <= 1'b0;
         for (int k = 0; k < N_CH; k++) data_r[k] <= '0;
      end else begin
         state   <= state_nxt;
         pending <= pending | accept;
         rdy_r   <= rdy_r & ~accept;
         if (take) begin
            grant <= pick;
            cnt   <= '0;
         end else if (state == ST_REQ || state == ST_WAIT) begin
            cnt <= cnt + 1'b1;
         end
         if (capture) data_r[grant] <= data_q;
         if (abort) begin
            data_r[grant] <= '0;
            tmo_r         <= 1'b1;
         end
         if (finish) begin
            rdy_r[grant]   <= 1'b1;
            pending[grant] <= 1'b0;
            ptr            <= grant;
         end
      end
   end

   // The idle ADC holds rdy high, so the sync stages reset high to avoid a
   // false edge right after reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rdy_q  <= 1'b1;
         rdy_d  <= 1'b1;
         data_q <= '0;
      end else begin
         rdy_q  <= adc_rdy_i;
         rdy_d  <= rdy_q;
         data_q <= adc_data_i;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_out
      assign ch_data_o[k*DATA_W +: DATA_W] = data_r[k];
   end

   assign ch_rdy_o  = rdy_r;
   assign adc_req_o = (state == ST_REQ);
   assign busy_o    = (state != ST_IDLE);
   assign timeout_o = tmo_r;

endmodule

// File: doc/adc_arbiter.md
# adc_arbiter

Shares one ADC among `N_CH` acquisition channels. Each channel presents the same level req/ready handshake the ADC itself uses. The block round-robin schedules their conversion requests onto the single ADC port and returns each result to the channel that requested it. It sits between the per-channel `data_acquire` instances and the ADC, and adds a conversion timeout so a stuck ADC cannot hang the channels.

## Interface
- `N_CH`, 4: number of requesting channels (2..8).
- `DATA_W`, 12: ADC sample width.
- `TIMEOUT`, 255: max cycles in ADC wait states before abort (≥16).
- `clk_i` in 1: single clock; all logic on rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `ch_req_i` in N_CH: per-channel conversion request (level).
- `ch_rdy_o` out N_CH: per-channel ready; high = idle/result valid, low = request accepted/in progress.
- `ch_data_o` out N_CH*DATA_W: per-channel result, channel k at [k*DATA_W +: DATA_W].
- `adc_req_o` out 1: request to ADC.
- `adc_rdy_i` in 1: ADC ready; falls on accept, rises when data valid.
- `adc_data_i` in DATA_W: ADC sample, valid while `adc_rdy_i` high after its rise.
- `busy_o` out 1: high when state ≠ IDLE.
- `timeout_o` out 1: sticky; set on any timeout abort, cleared only by reset.

## Operation
- Reset values: `ch_rdy_o` all 1, `ch_data_o` 0, `adc_req_o` 0, `busy_o` 0, `timeout_o` 0, `pending` 0, rr pointer = N_CH-1 (channel 0 wins first), state IDLE.
- Accept: `ch_req_i[k]`=1 with `ch_rdy_o[k]`=1 and `pending[k]`=0 → `pending[k]`<=1, `ch_rdy_o[k]`<=0 next cycle. A req held high after completion is re-accepted; the requester must drop req once it sees rdy low.
- `adc_rdy_i` and `adc_data_i` are registered together (1 stage). Edge detect uses the registered rdy and its delayed copy.
- FSM (one-hot):
  - IDLE: if any `pending`, pick the first set bit searching from ptr+1 upward with wrap. Latch `grant`, go REQ.
  - REQ: `adc_req_o`=1. When registered rdy=0 → WAIT, `adc_req_o`<=0.
  - WAIT: on rising edge of registered rdy → `ch_data_o[grant]`<=registered data, go DONE.
  - DONE: `ch_rdy_o[grant]`<=1, `pending[grant]`<=0, ptr<=grant, go IDLE.
- Timeout: a counter clears on entry to REQ and counts in REQ/WAIT. At `TIMEOUT` → `adc_req_o`<=0, `ch_data_o[grant]`<=0, `timeout_o`<=1, go DONE. The channel still completes its handshake.
- Simultaneous events:
  - An accept in the same cycle as IDLE arbitration is not visible until the next cycle; arbitration uses registered `pending` only.
  - `ch_req_i` of the granted channel is ignored until DONE completes.
- Reset mid-conversion: everything returns to reset values immediately. Any in-flight ADC result is discarded; a later `adc_rdy_i` rise in IDLE is ignored.
- Fairness: with all channels pending, service order is ptr+1, ptr+2, … A channel waits at most N_CH-1 conversions.

## Timing
- `ch_req_i[k]` rises at cycle t → `ch_rdy_o[k]`=0 at t+1, `busy_o`=1 and `adc_req_o`=1 at t+2 (when IDLE with no other pending).
- `adc_rdy_i` falls at cycle u → `adc_req_o`=0 at u+2.
- `adc_rdy_i` rises at cycle v → `ch_data_o` updated at v+2, `ch_rdy_o[k]`=1 at v+3, IDLE at v+3.
- Back-to-back: next `adc_req_o` asserts 1 cycle after IDLE is re-entered.
- `ch_data_o[k]` stays stable from its update until that channel's next completion.

## Structure
- Shared package `adc_pkg`:
  - one-hot state localparams ST_IDLE/ST_REQ/ST_WAIT/ST_DONE
  - `ADC_DATA_W` = 12
- Sub-module `rr_pick`: combinational round-robin picker.
  - inputs: request vector, pointer
  - outputs: grant index, any-valid
  - instantiated once.
- Top holds the FSM, pending/ready registers, input sync, timeout counter and output registers.

## Test plan
- Single request: ch2 req at t; ADC model drops rdy 3 cycles after req and rises with data 12'hA5C 10 cycles later → ch_data_o[2]=12'hA5C, ch_rdy_o[2] rises at v+3, other channels untouched.
- Contention: ch0..ch3 req in the same cycle, ADC returns 12'h100+k → grant order 0,1,2,3; each channel receives its own value; no two conversions overlap.
- Fairness: ch1 requests continuously, ch3 requests once → ch3 served no later than the 2nd conversion after its accept.
- Timeout: ADC never drops rdy, TIMEOUT=20 → adc_req_o falls after 20 cycles, ch_data_o[k]=0, ch_rdy_o[k]=1, timeout_o=1 and stays 1.
- Reset mid-WAIT: assert reset_i during WAIT, then release; ADC rdy later rises → all ch_rdy_o=1, no ch_data_o change, busy_o=0.
- Request during completion: ch0 re-asserts req in its DONE cycle → accepted on the cycle after ch_rdy_o[0] returns high; one extra conversion, no lost or duplicated result.
